// File: rtl/sdcard_pkg.sv
// sdcard_pkg: shared types and constants for the SD card SPI write path.
//   wr_state_e    - sector writer FSM states
//   card_type_e   - card type encoding, shared with the read side
//   CMD24, TOKEN_START, DATA_ACCEPTED, SECTOR_BYTES
//   crc16_byte()  - CRC16-CCITT (poly 0x1021) update over one byte, MSB first
package sdcard_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SEND_CMD, ST_WAIT_R1, ST_GAP, ST_TOKEN, ST_DATA,
    ST_CRC, ST_WAIT_RESP, ST_WAIT_BUSY, ST_RELEASE, ST_FAIL
  } wr_state_e;

  typedef enum logic [1:0] {
    CARD_UNKNOWN = 2'd0,
    CARD_SDV1    = 2'd1,
    CARD_SDV2    = 2'd2,
    CARD_SDHC    = 2'd3
  } card_type_e;

  localparam logic [7:0] CMD24         = 8'h58;
  localparam logic [7:0] TOKEN_START   = 8'hFE;
  localparam logic [4:0] DATA_ACCEPTED = 5'b00101;
  localparam int         SECTOR_BYTES  = 512;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// sd_spi_byte: SPI mode-0 byte shifter, MSB first.
//   start/tx_byte : load a byte and begin shifting (legal when idle or in the done cycle)
//   rx_byte       : byte captured from sd_miso, valid while done is high
//   done          : 1-cycle pulse in the last cycle of a byte; a start in that
//                   cycle chains the next byte with no idle gap
//   sd_clk/sd_mosi/sd_miso : SPI lines; sd_clk half period = ClockDivider cycles
module sd_spi_byte #(
  parameter int ClockDivider = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso
);

  localparam logic [15:0] DIV_LAST = 16'(ClockDivider - 1);

  logic        active;
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic        tick;

  assign tick    = active && (div_cnt == DIV_LAST);
  // Final falling edge of the byte happens on the edge that ends this cycle.
  assign done    = tick && sd_clk && (bit_cnt == 3'd7);
  assign sd_mosi = tx_sh[7];
  assign rx_byte = rx_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= 8'hFF;
      rx_sh   <= '0;
      sd_clk  <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= tx_byte;
      sd_clk  <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sd_clk  <= ~sd_clk;
      if (!sd_clk) begin
        rx_sh <= {rx_sh[6:0], sd_miso};
      end else if (bit_cnt == 3'd7) begin
        active <= 1'b0;
        tx_sh  <= 8'hFF;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        tx_sh   <= {tx_sh[6:0], 1'b1};
      end
    end else if (active) begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sdcard_writer.sv
// sdcard_writer: SPI-mode SD card single-sector writer (CMD24).
//   command        : 0 idle, 1 start write of sector_address, 2 store data_in at buffer index
//   sector_address : sector number, sampled on command 1
//   data_in        : byte for command 2
//   card_type      : card_type_e; SDHC uses block addressing, others byte addressing
//   busy / error   : write in progress / last write failed (sticky until next command 1)
//   sd_clk, sd_cs_n, sd_mosi, sd_miso : SPI bus
// Build option: SDCARD_WRITER_CRC16_EN sends a real CRC16 over the data block
// instead of 0xFFFF.
module sdcard_writer
  import sdcard_pkg::*;
#(
  parameter int ClockDivider     = 2,
  parameter int R1TimeoutBytes   = 8,
  parameter int BusyTimeoutBytes = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  command,
  input  logic [31:0] sector_address,
  input  logic [7:0]  data_in,
  input  logic [1:0]  card_type,
  output logic        busy,
  output logic        error,
  output logic        sd_clk,
  output logic        sd_cs_n,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam logic [15:0] R1_LAST   = 16'(R1TimeoutBytes - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BusyTimeoutBytes - 1);
  localparam logic [8:0]  IDX_LAST  = 9'(SECTOR_BYTES - 1);

  wr_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [8:0]  buf_idx, buf_idx_n;
  logic [31:0] addr;
  logic [7:0]  buffer [SECTOR_BYTES];
  logic        start, done, buf_we, launch, set_error;
  logic [7:0]  tx_byte, rx_byte, crc_hi, crc_lo;

  sd_spi_byte #(.ClockDivider(ClockDivider)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_byte (tx_byte),
    .rx_byte (rx_byte),
    .done    (done),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_miso (sd_miso)
  );

  assign busy    = (state != ST_IDLE);
  assign sd_cs_n = (state inside {ST_IDLE, ST_FAIL, ST_RELEASE});

  // The next byte is chosen in the done cycle so the shifter reloads on the
  // byte's final falling edge and the stream stays gap-free.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    buf_idx_n = buf_idx;
    start     = 1'b0;
    tx_byte   = 8'hFF;
    buf_we    = 1'b0;
    launch    = 1'b0;
    set_error = 1'b0;
    case (state)
      ST_IDLE: begin
        if (command == 2'd2) begin
          buf_we    = 1'b1;
          buf_idx_n = buf_idx + 9'd1;
        end else if (command == 2'd1) begin
          launch    = 1'b1;
          buf_idx_n = '0;
          cnt_n     = '0;
          state_n   = ST_SEND_CMD;
          start     = 1'b1;
          tx_byte   = CMD24;
        end
      end
      ST_SEND_CMD: if (done) begin
        start = 1'b1;
        if (cnt == 16'd5) begin
          state_n = ST_WAIT_R1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
          case (cnt_n[2:0])
            3'd1:    tx_byte = addr[31:24];
            3'd2:    tx_byte = addr[23:16];
            3'd3:    tx_byte = addr[15:8];
            3'd4:    tx_byte = addr[7:0];
            default: tx_byte = 8'hFF;  // CRC slot, ignored by the card in SPI mode
          endcase
        end
      end
      ST_WAIT_R1: if (done) begin
        if (rx_byte != 8'hFF) begin
          if (rx_byte == 8'h00) begin
            state_n = ST_GAP;
            start   = 1'b1;
          end else begin
            state_n = ST_FAIL;
          end
        end else if (cnt == R1_LAST) begin
          state_n = ST_FAIL;
        end else begin
          cnt_n = cnt + 16'd1;
          start = 1'b1;
        end
      end
      ST_GAP: if (done) begin
        state_n = ST_TOKEN;
        start   = 1'b1;
        tx_byte = TOKEN_START;
      end
      ST_TOKEN: if (done) begin
        state_n = ST_DATA;
        start   = 1'b1;
        tx_byte = buffer[buf_idx];
      end
      ST_DATA: if (done) begin
        buf_idx_n = buf_idx + 9'd1;
        start     = 1'b1;
        if (buf_idx == IDX_LAST) begin
          state_n = ST_CRC;
          cnt_n   = '0;
          tx_byte = crc_hi;
        end else begin
          tx_byte = buffer[buf_idx_n];
        end
      end
      ST_CRC: if (done) begin
        start = 1'b1;
        if (cnt == 16'd0) begin
          cnt_n   = 16'd1;
          tx_byte = crc_lo;
        end else begin
          state_n = ST_WAIT_RESP;
          cnt_n   = '0;
        end
      end
      ST_WAIT_RESP: if (done) begin
        if (rx_byte != 8'hFF) begin
          if (rx_byte[4:0] == DATA_ACCEPTED) begin
            state_n = ST_WAIT_BUSY;
            cnt_n   = '0;
            start   = 1'b1;
          end else begin
            state_n = ST_FAIL;
          end
        end else if (cnt == R1_LAST) begin
          state_n = ST_FAIL;
        end else begin
          cnt_n = cnt + 16'd1;
          start = 1'b1;
        end
      end
      ST_WAIT_BUSY: if (done) begin
        if (rx_byte == 8'hFF) begin
          state_n = ST_RELEASE;
          start   = 1'b1;
        end else if (cnt == BUSY_LAST) begin
          state_n = ST_FAIL;
        end else begin
          cnt_n = cnt + 16'd1;
          start = 1'b1;
        end
      end
      ST_FAIL: begin
        set_error = 1'b1;
        state_n   = ST_RELEASE;
        start     = 1'b1;
      end
      ST_RELEASE: if (done) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      buf_idx <= '0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      buf_idx <= buf_idx_n;
      if (set_error)   error <= 1'b1;
      else if (launch) error <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && buf_we) buffer[buf_idx] <= data_in;
    if (launch)
      addr <= (card_type_e'(card_type) == CARD_SDHC) ? sector_address
                                                     : {sector_address[22:0], 9'd0};
  end

`ifdef SDCARD_WRITER_CRC16_EN
  logic [15:0] crc;
  always_ff @(posedge clk) begin
    if (!rst_n || launch)                 crc <= '0;
    else if (start && state_n == ST_DATA) crc <= crc16_byte(crc, tx_byte);
  end
  assign crc_hi = crc[15:8];
  assign crc_lo = crc[7:0];
`else
  assign crc_hi = 8'hFF;
  assign crc_lo = 8'hFF;
`endif

endmodule

// File: tb/tb_sdcard_writer.sv
// tb_sdcard_writer: directed bench for sdcard_writer with a byte-level SPI card model.
// The model logs every byte seen while sd_cs_n is low and answers with a
// programmable R1, data response and busy length.
module tb_sdcard_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  command = 2'd0;
  logic [31:0] sector_address = '0;
  logic [7:0]  data_in = '0;
  logic [1:0]  card_type = 2'd0;
  logic        busy, error, sd_clk, sd_cs_n, sd_mosi, sd_miso;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sdcard_writer #(.ClockDivider(1), .R1TimeoutBytes(8), .BusyTimeoutBytes(20)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .command        (command),
    .sector_address (sector_address),
    .data_in        (data_in),
    .card_type      (card_type),
    .busy           (busy),
    .error          (error),
    .sd_clk         (sd_clk),
    .sd_cs_n        (sd_cs_n),
    .sd_mosi        (sd_mosi),
    .sd_miso        (sd_miso)
  );

  // ---------------- card model ----------------
  logic [7:0] m_log [0:1023];
  int         nlog = 0;
  int         m_bits = 0;
  logic [7:0] m_rx = 8'hFF, m_tx = 8'hFF, m_pend = 8'hFF;
  bit         m_load = 1'b0;
  logic [7:0] r1_val = 8'h00;
  logic [7:0] resp_val = 8'hE5;
  int         busy_n = 2;

  assign sd_miso = m_tx[7];

  // Byte layout of a full write: 0-5 cmd, 6 R1 poll, 7 gap, 8 token,
  // 9-520 data, 521-522 CRC, 523 response poll, 524.. busy polls.
  function automatic logic [7:0] next_resp(int k);
    if (k == 5)                           return r1_val;
    if (k == 522)                         return resp_val;
    if (k >= 523 && k < 523 + busy_n)     return 8'h00;
    return 8'hFF;
  endfunction

  always @(negedge sd_cs_n) begin
    nlog   = 0;
    m_bits = 0;
    m_tx   = 8'hFF;
    m_load = 1'b0;
  end

  always @(posedge sd_clk) begin
    if (!sd_cs_n) begin
      m_rx = {m_rx[6:0], sd_mosi};
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        if (nlog < 1024) m_log[nlog] = m_rx;
        m_pend = next_resp(nlog);
        nlog++;
        m_load = 1'b1;
      end
    end
  end

  always @(negedge sd_clk) begin
    if (!sd_cs_n) begin
      if (m_load) begin
        m_tx   = m_pend;
        m_load = 1'b0;
      end else begin
        m_tx = {m_tx[6:0], 1'b1};
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [31:0] sa, input logic [7:0] d);
    command        = c;
    sector_address = sa;
    data_in        = d;
    tick();
    command = 2'd0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  function automatic int data_mism(input bit ramp);
    int m;
    logic [7:0] e;
    m = 0;
    for (int i = 0; i < 512; i++) begin
      e = ramp ? 8'(i) : 8'hFF;
      if (m_log[9 + i] !== e) m++;
    end
    return m;
  endfunction

  logic [7:0] crc_hi_exp, crc_lo_exp;

  initial begin
`ifdef SDCARD_WRITER_CRC16_EN
    crc_hi_exp = 8'h7F;
    crc_lo_exp = 8'hA1;
`else
    crc_hi_exp = 8'hFF;
    crc_lo_exp = 8'hFF;
`endif
    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy",  {31'd0, busy},    32'd0);
    chk("rst_error", {31'd0, error},   32'd0);
    chk("rst_cs_n",  {31'd0, sd_cs_n}, 32'd1);
    chk("rst_sclk",  {31'd0, sd_clk},  32'd0);
    chk("rst_mosi",  {31'd0, sd_mosi}, 32'd1);
    rst_n = 1'b1;
    tick();

    // write 1: ramp buffer, SDHC block address
    for (int i = 0; i < 512; i++) do_cmd(2'd2, 32'd0, 8'(i));
    card_type = 2'd3;
    do_cmd(2'd1, 32'h10, 8'h00);
    chk("w1_busy_rise", {31'd0, busy}, 32'd1);
    wait_idle("w1_done");
    chk("w1_error", {31'd0, error}, 32'd0);
    chk("w1_nlog", nlog, 527);
    chk("w1_cmd", {24'd0, m_log[0]}, 32'h58);
    chk("w1_arg", {m_log[1], m_log[2], m_log[3], m_log[4]}, 32'h0000_0010);
    chk("w1_token", {24'd0, m_log[8]}, 32'hFE);
    chk("w1_data", data_mism(1'b1), 0);
    chk("w1_cs_n", {31'd0, sd_cs_n}, 32'd1);

    // write 2: SDv1 byte address; commands during the write are ignored
    card_type = 2'd1;
    do_cmd(2'd1, 32'h10, 8'h00);
    repeat (3) tick();
    do_cmd(2'd2, 32'd0, 8'hAA);
    do_cmd(2'd1, 32'h77, 8'h00);
    chk("w2_still_busy", {31'd0, busy}, 32'd1);
    wait_idle("w2_done");
    chk("w2_error", {31'd0, error}, 32'd0);
    chk("w2_arg", {m_log[1], m_log[2], m_log[3], m_log[4]}, 32'h0000_2000);
    chk("w2_nlog", nlog, 527);
    chk("w2_data", data_mism(1'b1), 0);

    // write 3: R1 reject, no token sent
    r1_val = 8'h04;
    do_cmd(2'd1, 32'h10, 8'h00);
    wait_idle("w3_done");
    chk("w3_error", {31'd0, error}, 32'd1);
    chk("w3_nlog", nlog, 7);
    chk("w3_cs_n", {31'd0, sd_cs_n}, 32'd1);
    r1_val = 8'h00;

    // write 4: all-0xFF buffer, data response CRC reject
    for (int i = 0; i < 512; i++) do_cmd(2'd2, 32'd0, 8'hFF);
    resp_val = 8'h0B;
    do_cmd(2'd1, 32'h10, 8'h00);
    chk("w4_error_clr", {31'd0, error}, 32'd0);
    wait_idle("w4_done");
    chk("w4_error", {31'd0, error}, 32'd1);
    chk("w4_nlog", nlog, 524);
    chk("w4_crc_hi", {24'd0, m_log[521]}, {24'd0, crc_hi_exp});
    chk("w4_crc_lo", {24'd0, m_log[522]}, {24'd0, crc_lo_exp});

    // write 5: same buffer, accepted response (masked 0xE5)
    resp_val = 8'hE5;
    do_cmd(2'd1, 32'h10, 8'h00);
    wait_idle("w5_done");
    chk("w5_error", {31'd0, error}, 32'd0);
    chk("w5_nlog", nlog, 527);
    chk("w5_data", data_mism(1'b0), 0);

    // write 6: card never leaves busy
    busy_n = 100000;
    do_cmd(2'd1, 32'h10, 8'h00);
    wait_idle("w6_done");
    chk("w6_error", {31'd0, error}, 32'd1);
    chk("w6_nlog", nlog, 544);
    busy_n = 2;

    // write 7: reset in the middle of the data phase
    do_cmd(2'd1, 32'h10, 8'h00);
    begin
      int n;
      n = 0;
      while (nlog < 20 && n < 5000) begin
        tick();
        n++;
      end
    end
    chk("w7_in_data", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("w7_rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
    chk("w7_rst_busy", {31'd0, busy},    32'd0);
    chk("w7_rst_sclk", {31'd0, sd_clk},  32'd0);
    chk("w7_rst_mosi", {31'd0, sd_mosi}, 32'd1);
    chk("w7_rst_err",  {31'd0, error},   32'd0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sdcard_writer.md
Name: sdcard_writer

Overview:
SPI-mode SD card sector writer, the write-side counterpart of the sector read interface.
- Holds a 512-byte sector buffer that the CPU/bus side fills one byte at a time.
- On command, issues CMD24 (WRITE_BLOCK), streams the buffer with start token and CRC, checks the data-response token, and waits out card busy.
- The card must already be initialized (SPI mode, type known) by the read path; a top-level mux grants this block the SD lines while `busy`.

Parameters:
- ClockDivider, 2, `sd_clk` half period in `clk` cycles (≥1); one byte time = 16*ClockDivider cycles.
- R1TimeoutBytes, 8, max byte times polled for R1 after CMD24.
- BusyTimeoutBytes, 65535, max byte times polled for end of card busy.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- command  in  2  0 = idle; 1 = start write of `sector_address`; 2 = store `data_in` at buffer_index, then increment the index.
- sector_address  in  32  sector to write, sampled on command 1.
- data_in  in  8  byte for command 2.
- card_type  in  2  0 = unknown, 1 = SDv1, 2 = SDv2, 3 = SDHCv2.
- busy  out  1  high while a write is in progress.
- error  out  1  last write failed; sticky until next command 1.
- sd_clk  out  1  SPI clock.
- sd_cs_n  out  1  card select, active low.
- sd_mosi  out  1  SPI data to card.
- sd_miso  in  1  SPI data from card.

Behaviour:
- Reset values: busy=0, error=0, sd_cs_n=1, sd_clk=0, sd_mosi=1, buffer_index=0, state=Idle. Buffer RAM is not reset. Reset mid-write aborts immediately; these values hold on the following cycle.
- SPI mode 0:
  - `sd_mosi` changes only while `sd_clk` is low; `sd_miso` is sampled on the rising edge.
  - MSB first; idle `sd_mosi`=1.
  - Bytes are back-to-back, with no idle gaps within a state sequence.
- Idle:
  - command 2 writes `buffer[buffer_index]` and increments buffer_index; 511 wraps to 0.
  - command 1 latches the address, sets buffer_index=0, clears error, and goes to SendCmd; `busy`=1 on the next cycle.
  - Commands 1 and 2 are ignored while `busy`.
- Address: card_type==3 → `sector_address`; otherwise `sector_address`<<9, truncated to 32 bits.
- States:
  - SendCmd: `sd_cs_n`=0; send 0x58, 4 address bytes MSB first, then 0xFF.
  - WaitR1: send 0xFF and capture each byte until a byte ≠ 0xFF.
    - 0x00 → Gap; any other value → Fail.
    - No response within R1TimeoutBytes → Fail.
  - Gap: send one 0xFF.
  - Token: send 0xFE.
  - Data: send `buffer[0..511]`; buffer_index ends at 0 after rollover.
  - Crc: send 2 CRC bytes, 0xFF 0xFF by default.
  - WaitResp: send 0xFF until a byte ≠ 0xFF (limit R1TimeoutBytes).
    - (byte & 0x1F)==0x05 → WaitBusy; otherwise Fail.
  - WaitBusy: send 0xFF until a received byte ==0xFF; exceeding BusyTimeoutBytes → Fail.
  - Release: `sd_cs_n`=1; send one 0xFF (8 trailing clocks); then `busy`=0 → Idle.
  - Fail: error=1, then go via Release.
- The `busy` falling edge and the `error` value are valid in the same cycle.

Optional Feature:
- Macro: SDCARD_WRITER_CRC16_EN.
- Defined: a CRC16-CCITT (poly 0x1021, init 0x0000) is computed over the 512 data bytes as they are sent, and its 2 bytes are transmitted MSB first in Crc.
- Undefined: Crc sends 0xFFFF and the CRC logic is absent.

Decomposition:
- Package sdcard_pkg holds:
  - state enum;
  - constants CMD24=8'h58, TOKEN_START=8'hFE, DATA_ACCEPTED=5'b00101, SECTOR_BYTES=512;
  - card_type encoding, shared with the read side.
- Sub-module sd_spi_byte: a byte shifter with start/tx_byte/rx_byte/done.
  - It generates `sd_clk` from ClockDivider.
  - done pulses for 1 cycle per byte.

Test Plan (against an SPI card model):
- Fill the buffer with i&0xFF via 512× command 2, then command 1 with sector 0x10, card_type=3.
  - Model captures CMD24 with arg 0x00000010, token 0xFE, bytes 0..255,0..255.
  - `busy` drops with error=0.
- Same write with card_type=1, sector 0x10 → CMD24 argument 0x00002000.
- Model returns R1=0x04 → no token sent; `sd_cs_n` rises; error=1, `busy`=0.
- Model returns data response 0x0B (CRC reject) → error=1. With a model never releasing busy, error=1 after BusyTimeoutBytes.
- Command 2 and command 1 issued during a write → no buffer change and no restart. rst_n pulsed mid-Data → next cycle `sd_cs_n`=1, `busy`=0, `sd_clk`=0.
- With SDCARD_WRITER_CRC16_EN and an all-0xFF buffer → CRC bytes 0x7F 0xA1, and the model accepts.
